pb_debounce_array: RTL and testbench
====================================

# pb_debounce_array

Parametrised N-channel push-button conditioner: the next generation of the board's fixed 4-button cross-talk filter. Per channel it synchronises the raw active-low button, debounces it with a programmable stability window, optionally suppresses simultaneous presses (cross-talk lock-out), and produces press/release strobes, a long-press flag and sticky event bits. It sits between the `pb_n` pins and the Qsys button PIO / interrupt logic in the top level.

## Interface
- `N`, 4, number of button channels (1..16)
- `CNT_W`, 16, width of the per-channel debounce and hold counters
- `STABLE_CYCLES`, 50000, clocks a synchronised level must persist before acceptance (1 ms at 50 MHz); 1..2^CNT_W-1
- `HOLD_CYCLES`, 0, clocks a press must persist after acceptance to assert `held`; 0 disables; ≤2^CNT_W-1
- `EXCLUSIVE`, 1, 1 = cross-talk lock-out (at most one channel filtered-pressed), 0 = independent channels
- `clk`  in  1  system clock (clkin_50 domain)
- `rst_n`  in  1  reset, asynchronous, active-low
- `pb_n`  in  N  raw buttons, active-low, asynchronous to `clk`
- `evt_clr`  in  N  per-channel clear of `evt_sticky`, sampled on `clk`
- `pb_n_fltrd`  out  N  debounced level, active-low
- `press_pulse`  out  N  one-cycle strobe on accepted press
- `release_pulse`  out  N  one-cycle strobe on accepted release
- `held`  out  N  long-press level
- `evt_sticky`  out  N  latched press events

## Operation
- Reset (async, all outputs registered): sync flops = 1, `pb_n_fltrd` = all 1, counters = 0, `press_pulse` = `release_pulse` = `held` = `evt_sticky` = 0.
- Sync: two-flop synchroniser per channel; `s[i]` = second stage.
- Debounce, per channel: if `s[i]` == `pb_n_fltrd[i]`, debounce counter ← 0. Else if counter == STABLE_CYCLES-1, request a transition and clear counter; else counter + 1. Any return to the filtered level before threshold clears the counter (glitch rejected).
- Release request (1→... i.e. fltrd 0→1): always granted; `pb_n_fltrd[i]` ← 1, `release_pulse[i]` ← 1, `held[i]` ← 0, hold counter ← 0.
- Press request, EXCLUSIVE=0: always granted.
- Press request, EXCLUSIVE=1: granted only if no channel is filtered-pressed at that cycle and it is the lowest-indexed requesting channel this cycle. A denied request clears its debounce counter; the channel must then re-qualify a full window.
- Granted press: `pb_n_fltrd[i]` ← 0, `press_pulse[i]` ← 1, `evt_sticky[i]` ← 1, hold counter ← 0.
- Hold (HOLD_CYCLES>0): while `pb_n_fltrd[i]` = 0, hold counter increments, saturating; when it reaches HOLD_CYCLES-1, `held[i]` ← 1 next edge. Cleared only by accepted release or reset. HOLD_CYCLES=0: `held` constantly 0.
- Sticky: `evt_sticky[i]` cleared by `evt_clr[i]`; a press grant in the same cycle as clear wins (bit stays 1).
- Counters never wrap: debounce clears at threshold, hold saturates.

## Timing
- `pb_n` edge → `s` change: 2 clocks (plus ≤1 for metastability resolution).
- `s` change, held stable → `pb_n_fltrd` change: STABLE_CYCLES clocks; total pin-to-output STABLE_CYCLES+2.
- `press_pulse`/`release_pulse` high exactly the cycle `pb_n_fltrd` first shows the new level; never two consecutive cycles.
- `held` rises HOLD_CYCLES clocks after `pb_n_fltrd` falls.
- Glitches of fewer than STABLE_CYCLES synchronised cycles produce no output activity.
- Reset mid-debounce or mid-hold: all state returns to reset values immediately; after release of reset a still-pressed button re-qualifies a full window.

## Test plan
Bench parameters N=4, STABLE_CYCLES=4, HOLD_CYCLES=10, EXCLUSIVE=1 unless stated.
- Clean press: `pb_n`=1110 held 20 clk → `pb_n_fltrd[0]` falls and `press_pulse[0]` pulses 1 clk exactly 6 clk after the edge; `evt_sticky`=0001; `held[0]` rises 10 clk after fltrd fall; release → `release_pulse[0]`, `held[0]`=0.
- Glitch: `pb_n[1]` low for 3 synchronised clk, then high → no change on any output; low 4 clk → accepted.
- Cross-talk: pb 0 and 2 pressed same cycle → only channel 0 accepted; channel 2 stays 1 while 0 held; release 0 → channel 2 accepted 4 clk after grant becomes possible (re-qualified window).
- EXCLUSIVE=0: pb 0 and 2 pressed together → both fltrd fall and both `press_pulse` assert in the same cycle.
- Sticky: `evt_clr[0]` asserted the cycle of a channel-0 press grant → `evt_sticky[0]` stays 1; later `evt_clr[0]` alone → 0.
- Reset mid-operation: assert `rst_n`=0 asynchronously while channel 3 held → all outputs at reset values within the same cycle; deassert with button still low → press re-accepted after 6 clk.

Source files
------------

// File: rtl/pb_debounce_array.sv
// N-channel push-button conditioner: synchroniser, programmable debounce window,
// optional cross-talk lock-out, press/release strobes, long-press flag, sticky events.
module pb_debounce_array #(
  parameter int N             = 4,
  parameter int CNT_W         = 16,
  parameter int STABLE_CYCLES = 50000,
  parameter int HOLD_CYCLES   = 0,
  parameter bit EXCLUSIVE     = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] pb_n,
  input  logic [N-1:0] evt_clr,
  output logic [N-1:0] pb_n_fltrd,
  output logic [N-1:0] press_pulse,
  output logic [N-1:0] release_pulse,
  output logic [N-1:0] held,
  output logic [N-1:0] evt_sticky
);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = (HOLD_CYCLES > 0) ? CNT_W'(HOLD_CYCLES - 1) : '0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    return (v >= lim) ? v : v + CNT_W'(1);
  endfunction

  logic [N-1:0]     r_sync_p0;
  logic [N-1:0]     r_sync_p1;
  logic [N-1:0]     r_fltrd_n;
  logic [N-1:0]     r_press;
  logic [N-1:0]     r_release;
  logic [N-1:0]     r_held;
  logic [N-1:0]     r_sticky;
  logic [CNT_W-1:0] r_dbc_cnt  [N];
  logic [CNT_W-1:0] r_hold_cnt [N];

  logic [N-1:0] w_s;
  logic [N-1:0] w_req_press;
  logic [N-1:0] w_req_rel;
  logic [N-1:0] w_lowest;
  logic [N-1:0] w_grant;
  logic         w_any_pressed;

  assign w_s = r_sync_p1;

  always_comb begin
    w_req_press = '0;
    w_req_rel   = '0;
    for (int i = 0; i < N; i++) begin
      w_req_press[i] = r_fltrd_n[i] & ~w_s[i] & (r_dbc_cnt[i] == STABLE_LAST);
      w_req_rel[i]   = ~r_fltrd_n[i] & w_s[i] & (r_dbc_cnt[i] == STABLE_LAST);
    end
  end

  // Lock-out: isolate the lowest requesting channel, and only while nobody is pressed.
  assign w_any_pressed = ~&r_fltrd_n;
  assign w_lowest      = w_req_press & (~w_req_press + N'(1));

  always_comb begin
    w_grant = w_req_press;
    if (EXCLUSIVE) begin
      w_grant = w_any_pressed ? '0 : w_lowest;
    end
  end

  // Stage p0/p1: synchroniser; then debounce, grant and hold state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_p0 <= '1;
      r_sync_p1 <= '1;
      r_fltrd_n <= '1;
      r_press   <= '0;
      r_release <= '0;
      r_held    <= '0;
      r_sticky  <= '0;
      for (int i = 0; i < N; i++) begin
        r_dbc_cnt[i]  <= '0;
        r_hold_cnt[i] <= '0;
      end
    end else begin
      r_sync_p0 <= pb_n;
      r_sync_p1 <= r_sync_p0;
      r_press   <= w_grant;
      r_release <= w_req_rel;
      for (int i = 0; i < N; i++) begin
        // A denied press also lands here, forcing a fresh full window.
        if (w_s[i] == r_fltrd_n[i] || r_dbc_cnt[i] == STABLE_LAST) begin
          r_dbc_cnt[i] <= '0;
        end else begin
          r_dbc_cnt[i] <= r_dbc_cnt[i] + CNT_W'(1);
        end

        if (w_req_rel[i]) begin
          r_fltrd_n[i]  <= 1'b1;
          r_held[i]     <= 1'b0;
          r_hold_cnt[i] <= '0;
        end else if (w_grant[i]) begin
          r_fltrd_n[i]  <= 1'b0;
          r_hold_cnt[i] <= '0;
        end else if (!r_fltrd_n[i] && (HOLD_CYCLES > 0)) begin
          if (r_hold_cnt[i] == HOLD_LAST) begin
            r_held[i] <= 1'b1;
          end
          r_hold_cnt[i] <= sat_inc(r_hold_cnt[i], HOLD_LAST);
        end

        if (w_grant[i]) begin
          r_sticky[i] <= 1'b1;
        end else if (evt_clr[i]) begin
          r_sticky[i] <= 1'b0;
        end
      end
    end
  end

  assign pb_n_fltrd    = r_fltrd_n;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign held          = r_held;
  assign evt_sticky    = r_sticky;

endmodule

// File: tb/tb_pb_debounce_array.sv
// Directed bench for pb_debounce_array: STABLE_CYCLES=4, HOLD_CYCLES=10, plus a
// second instance with the lock-out disabled.
module tb_pb_debounce_array;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] pb_n, evt_clr, pb_n_x, evt_clr_x;
  logic [3:0] fltrd, press, rel, held, sticky;
  logic [3:0] fltrd_x, press_x, rel_x, held_x, sticky_x;
  logic [3:0] exp_sticky;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pb_debounce_array #(.N(4), .CNT_W(16), .STABLE_CYCLES(4), .HOLD_CYCLES(10), .EXCLUSIVE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .pb_n(pb_n), .evt_clr(evt_clr),
    .pb_n_fltrd(fltrd), .press_pulse(press), .release_pulse(rel), .held(held), .evt_sticky(sticky)
  );

  pb_debounce_array #(.N(4), .CNT_W(16), .STABLE_CYCLES(4), .HOLD_CYCLES(10), .EXCLUSIVE(1'b0)) dut_x (
    .clk(clk), .rst_n(rst_n), .pb_n(pb_n_x), .evt_clr(evt_clr_x),
    .pb_n_fltrd(fltrd_x), .press_pulse(press_x), .release_pulse(rel_x), .held(held_x), .evt_sticky(sticky_x)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pb_n = 4'b1111; evt_clr = 4'b0000; pb_n_x = 4'b1111; evt_clr_x = 4'b0000;
    exp_sticky = 4'b0000;
    ticks(2);
    checks++; if (fltrd !== 4'b1111) begin errors++; $display("FAIL reset_fltrd: got %b expected %b", fltrd, 4'b1111); end
    checks++; if (press !== 4'b0000) begin errors++; $display("FAIL reset_press: got %b expected %b", press, 4'b0000); end
    checks++; if (rel !== 4'b0000) begin errors++; $display("FAIL reset_release: got %b expected %b", rel, 4'b0000); end
    checks++; if (held !== 4'b0000) begin errors++; $display("FAIL reset_held: got %b expected %b", held, 4'b0000); end
    checks++; if (sticky !== 4'b0000) begin errors++; $display("FAIL reset_sticky: got %b expected %b", sticky, 4'b0000); end
    checks++; if (fltrd_x !== 4'b1111) begin errors++; $display("FAIL reset_fltrd_x: got %b expected %b", fltrd_x, 4'b1111); end
    rst_n = 1'b1;
    ticks(2);
  endtask

  task automatic test_clean_press();
    pb_n = 4'b1110;
    ticks(5);
    checks++; if (fltrd !== 4'b1111) begin errors++; $display("FAIL clean_pre_fltrd: got %b expected %b", fltrd, 4'b1111); end
    checks++; if (press !== 4'b0000) begin errors++; $display("FAIL clean_pre_press: got %b expected %b", press, 4'b0000); end
    tick();
    exp_sticky = 4'b0001;
    checks++; if (fltrd !== 4'b1110) begin errors++; $display("FAIL clean_fltrd: got %b expected %b", fltrd, 4'b1110); end
    checks++; if (press !== 4'b0001) begin errors++; $display("FAIL clean_press: got %b expected %b", press, 4'b0001); end
    checks++; if (sticky !== exp_sticky) begin errors++; $display("FAIL clean_sticky: got %b expected %b", sticky, exp_sticky); end
    tick();
    checks++; if (press !== 4'b0000) begin errors++; $display("FAIL clean_press_one_cycle: got %b expected %b", press, 4'b0000); end
    ticks(8);
    checks++; if (held !== 4'b0000) begin errors++; $display("FAIL clean_held_early: got %b expected %b", held, 4'b0000); end
    tick();
    checks++; if (held !== 4'b0001) begin errors++; $display("FAIL clean_held: got %b expected %b", held, 4'b0001); end
    pb_n = 4'b1111;
    ticks(5);
    checks++; if (fltrd !== 4'b1110) begin errors++; $display("FAIL clean_rel_pre_fltrd: got %b expected %b", fltrd, 4'b1110); end
    tick();
    checks++; if (fltrd !== 4'b1111) begin errors++; $display("FAIL clean_rel_fltrd: got %b expected %b", fltrd, 4'b1111); end
    checks++; if (rel !== 4'b0001) begin errors++; $display("FAIL clean_rel_pulse: got %b expected %b", rel, 4'b0001); end
    checks++; if (held !== 4'b0000) begin errors++; $display("FAIL clean_rel_held: got %b expected %b", held, 4'b0000); end
    tick();
    checks++; if (rel !== 4'b0000) begin errors++; $display("FAIL clean_rel_one_cycle: got %b expected %b", rel, 4'b0000); end
  endtask

  task automatic test_glitch();
    pb_n = 4'b1101;
    ticks(3);
    pb_n = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if ({fltrd, press, rel, held} !== {4'b1111, 4'b0000, 4'b0000, 4'b0000}) begin
        errors++;
        $display("FAIL glitch_quiet: got fltrd=%b press=%b rel=%b held=%b expected 1111/0000/0000/0000", fltrd, press, rel, held);
      end
    end
    pb_n = 4'b1101;
    ticks(4);
    pb_n = 4'b1111;
    tick();
    checks++; if (fltrd !== 4'b1111) begin errors++; $display("FAIL glitch4_pre_fltrd: got %b expected %b", fltrd, 4'b1111); end
    tick();
    exp_sticky = 4'b0011;
    checks++; if (fltrd !== 4'b1101) begin errors++; $display("FAIL glitch4_fltrd: got %b expected %b", fltrd, 4'b1101); end
    checks++; if (press !== 4'b0010) begin errors++; $display("FAIL glitch4_press: got %b expected %b", press, 4'b0010); end
    ticks(3);
    checks++; if (fltrd !== 4'b1101) begin errors++; $display("FAIL glitch4_rel_pre: got %b expected %b", fltrd, 4'b1101); end
    tick();
    checks++; if (fltrd !== 4'b1111) begin errors++; $display("FAIL glitch4_rel_fltrd: got %b expected %b", fltrd, 4'b1111); end
    checks++; if (rel !== 4'b0010) begin errors++; $display("FAIL glitch4_rel_pulse: got %b expected %b", rel, 4'b0010); end
    checks++; if (held !== 4'b0000) begin errors++; $display("FAIL glitch4_held: got %b expected %b", held, 4'b0000); end
  endtask

  task automatic test_cross_talk();
    tick();
    pb_n = 4'b1010;
    ticks(5);
    checks++; if (fltrd !== 4'b1111) begin errors++; $display("FAIL xtalk_pre_fltrd: got %b expected %b", fltrd, 4'b1111); end
    tick();
    exp_sticky = 4'b0011;
    checks++; if (fltrd !== 4'b1110) begin errors++; $display("FAIL xtalk_fltrd: got %b expected %b", fltrd, 4'b1110); end
    checks++; if (press !== 4'b0001) begin errors++; $display("FAIL xtalk_press: got %b expected %b", press, 4'b0001); end
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if ({fltrd, press} !== {4'b1110, 4'b0000}) begin
        errors++;
        $display("FAIL xtalk_locked: got fltrd=%b press=%b expected 1110/0000", fltrd, press);
      end
    end
    pb_n = 4'b1011;
    ticks(5);
    checks++; if (fltrd !== 4'b1110) begin errors++; $display("FAIL xtalk_rel_pre: got %b expected %b", fltrd, 4'b1110); end
    tick();
    checks++; if (fltrd !== 4'b1111) begin errors++; $display("FAIL xtalk_rel_fltrd: got %b expected %b", fltrd, 4'b1111); end
    checks++; if (rel !== 4'b0001) begin errors++; $display("FAIL xtalk_rel_pulse: got %b expected %b", rel, 4'b0001); end
    checks++; if (press !== 4'b0000) begin errors++; $display("FAIL xtalk_rel_press: got %b expected %b", press, 4'b0000); end
    ticks(3);
    checks++; if (fltrd !== 4'b1111) begin errors++; $display("FAIL xtalk_requal_pre: got %b expected %b", fltrd, 4'b1111); end
    tick();
    exp_sticky = 4'b0111;
    checks++; if (fltrd !== 4'b1011) begin errors++; $display("FAIL xtalk_ch2_fltrd: got %b expected %b", fltrd, 4'b1011); end
    checks++; if (press !== 4'b0100) begin errors++; $display("FAIL xtalk_ch2_press: got %b expected %b", press, 4'b0100); end
    checks++; if (sticky !== exp_sticky) begin errors++; $display("FAIL xtalk_sticky: got %b expected %b", sticky, exp_sticky); end
    pb_n = 4'b1111;
    ticks(5);
    checks++; if (fltrd !== 4'b1011) begin errors++; $display("FAIL xtalk_ch2_rel_pre: got %b expected %b", fltrd, 4'b1011); end
    tick();
    checks++; if (rel !== 4'b0100) begin errors++; $display("FAIL xtalk_ch2_rel: got %b expected %b", rel, 4'b0100); end
    checks++; if (fltrd !== 4'b1111) begin errors++; $display("FAIL xtalk_ch2_rel_fltrd: got %b expected %b", fltrd, 4'b1111); end
  endtask

  task automatic test_exclusive_off();
    pb_n_x = 4'b1010;
    ticks(5);
    checks++; if (fltrd_x !== 4'b1111) begin errors++; $display("FAIL indep_pre_fltrd: got %b expected %b", fltrd_x, 4'b1111); end
    tick();
    checks++; if (fltrd_x !== 4'b1010) begin errors++; $display("FAIL indep_fltrd: got %b expected %b", fltrd_x, 4'b1010); end
    checks++; if (press_x !== 4'b0101) begin errors++; $display("FAIL indep_press: got %b expected %b", press_x, 4'b0101); end
    checks++; if (sticky_x !== 4'b0101) begin errors++; $display("FAIL indep_sticky: got %b expected %b", sticky_x, 4'b0101); end
    tick();
    checks++; if (press_x !== 4'b0000) begin errors++; $display("FAIL indep_press_one_cycle: got %b expected %b", press_x, 4'b0000); end
    pb_n_x = 4'b1111;
    ticks(8);
  endtask

  task automatic test_sticky();
    evt_clr = 4'b0001;
    tick();
    evt_clr = 4'b0000;
    exp_sticky = 4'b0110;
    checks++; if (sticky !== exp_sticky) begin errors++; $display("FAIL sticky_clear_first: got %b expected %b", sticky, exp_sticky); end
    pb_n = 4'b1110;
    ticks(5);
    evt_clr = 4'b0001;
    tick();
    evt_clr = 4'b0000;
    exp_sticky = 4'b0111;
    checks++; if (press !== 4'b0001) begin errors++; $display("FAIL sticky_press: got %b expected %b", press, 4'b0001); end
    checks++; if (sticky !== exp_sticky) begin errors++; $display("FAIL sticky_grant_wins: got %b expected %b", sticky, exp_sticky); end
    tick();
    checks++; if (sticky !== exp_sticky) begin errors++; $display("FAIL sticky_holds: got %b expected %b", sticky, exp_sticky); end
    evt_clr = 4'b0001;
    tick();
    evt_clr = 4'b0000;
    exp_sticky = 4'b0110;
    checks++; if (sticky !== exp_sticky) begin errors++; $display("FAIL sticky_clear_alone: got %b expected %b", sticky, exp_sticky); end
    pb_n = 4'b1111;
    ticks(6);
    checks++; if (rel !== 4'b0001) begin errors++; $display("FAIL sticky_rel_pulse: got %b expected %b", rel, 4'b0001); end
    checks++; if (fltrd !== 4'b1111) begin errors++; $display("FAIL sticky_rel_fltrd: got %b expected %b", fltrd, 4'b1111); end
  endtask

  task automatic test_reset_mid();
    tick();
    pb_n = 4'b0111;
    ticks(16);
    checks++; if (fltrd !== 4'b0111) begin errors++; $display("FAIL rstmid_fltrd: got %b expected %b", fltrd, 4'b0111); end
    checks++; if (held !== 4'b1000) begin errors++; $display("FAIL rstmid_held: got %b expected %b", held, 4'b1000); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (fltrd !== 4'b1111) begin errors++; $display("FAIL rstmid_async_fltrd: got %b expected %b", fltrd, 4'b1111); end
    checks++; if (held !== 4'b0000) begin errors++; $display("FAIL rstmid_async_held: got %b expected %b", held, 4'b0000); end
    checks++; if (sticky !== 4'b0000) begin errors++; $display("FAIL rstmid_async_sticky: got %b expected %b", sticky, 4'b0000); end
    checks++; if ({press, rel} !== 8'h00) begin errors++; $display("FAIL rstmid_async_pulses: got %b expected %b", {press, rel}, 8'h00); end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    ticks(5);
    checks++; if (fltrd !== 4'b1111) begin errors++; $display("FAIL rstmid_requal_pre: got %b expected %b", fltrd, 4'b1111); end
    tick();
    checks++; if (fltrd !== 4'b0111) begin errors++; $display("FAIL rstmid_requal_fltrd: got %b expected %b", fltrd, 4'b0111); end
    checks++; if (press !== 4'b1000) begin errors++; $display("FAIL rstmid_requal_press: got %b expected %b", press, 4'b1000); end
    checks++; if (sticky !== 4'b1000) begin errors++; $display("FAIL rstmid_requal_sticky: got %b expected %b", sticky, 4'b1000); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_cross_talk();
    test_exclusive_off();
    test_sticky();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
